// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin arbiter sharing the fifo_buffer write port among NUM_REQ producers.
// Optional FIFO_ARB_PRIO0_EN: requester 0 wins every selection point.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int THRES_RST = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fifo_full,
  output logic                      fifo_write_enable,
  output logic [DATA_W-1:0]         fifo_data_in,
  input  logic [5:0]                cfg_thres,
  input  logic                      cfg_thres_load,
  output logic [5:0]                fifo_full_thres,
  output logic                      busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [1:0] rr_ptr;
  logic [3:0] burst_cnt;
  logic       thres_pend;
  logic [5:0] thres_pend_val;

  logic [1:0] g_idx;
  logic       accept;
  logic       release_g;
  logic [1:0] next_ptr;
  logic [1:0] sel_ptr;
  logic [1:0] sel_idx;

  // First set bit of r searching ptr, ptr+1, ... mod 4.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) g_idx = 2'(i);
    end
  end

  assign accept            = (|(gnt & req)) & ~fifo_full;
  assign fifo_write_enable = accept;
  assign busy              = (state == GRANT);
  assign release_g         = (accept && (burst_cnt == 4'(BURST_LEN - 1))) || !req[g_idx];

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && gnt[i]) fifo_data_in = req_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef FIFO_ARB_PRIO0_EN
  assign next_ptr = (g_idx == 2'd0) ? rr_ptr : g_idx + 2'd1;
  assign sel_ptr  = (state == GRANT) ? next_ptr : rr_ptr;
  assign sel_idx  = req[0] ? 2'd0 : rr_pick(req & ~NUM_REQ'(1), sel_ptr);
`else
  assign next_ptr = g_idx + 2'd1;
  assign sel_ptr  = (state == GRANT) ? next_ptr : rr_ptr;
  // With sel_ptr = g+1 the current holder is searched last, so others win before a re-grant.
  assign sel_idx  = rr_pick(req, sel_ptr);
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      gnt             <= '0;
      rr_ptr          <= '0;
      burst_cnt       <= '0;
      fifo_full_thres <= 6'(THRES_RST);
      thres_pend      <= 1'b0;
      thres_pend_val  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= NUM_REQ'(1) << sel_idx;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        default: begin
          if (release_g) begin
            rr_ptr    <= next_ptr;
            burst_cnt <= '0;
            if (|req) begin
              gnt <= NUM_REQ'(1) << sel_idx;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end else if (accept) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
      endcase

      // Threshold changes only take effect while no burst is in flight.
      if (state == IDLE) begin
        if (cfg_thres_load) fifo_full_thres <= cfg_thres;
        else if (thres_pend) fifo_full_thres <= thres_pend_val;
        thres_pend <= 1'b0;
      end else if (cfg_thres_load) begin
        thres_pend     <= 1'b1;
        thres_pend_val <= cfg_thres;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for fifo_write_arbiter.
module tb_fifo_write_arbiter;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_write_enable;
  logic [7:0]  fifo_data_in;
  logic [5:0]  cfg_thres;
  logic        cfg_thres_load;
  logic [5:0]  fifo_full_thres;
  logic        busy;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  fifo_write_arbiter dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_write_enable(fifo_write_enable), .fifo_data_in(fifo_data_in),
    .cfg_thres(cfg_thres), .cfg_thres_load(cfg_thres_load), .fifo_full_thres(fifo_full_thres),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Every write seen by the FIFO must match the head of the scoreboard.
  always @(negedge clock) begin
    if (fifo_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("extra_write", {24'h0, fifo_data_in}, 32'hffff_ffff);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_data", {24'h0, fifo_data_in}, {24'h0, e.d});
        check("wr_gnt", {28'h0, gnt}, {28'h0, e.g});
      end
    end
  end

  task automatic push(input logic [3:0] g, input logic [7:0] d, input int n);
    wr_t e;
    e.g = g;
    e.d = d;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    req            = '0;
    fifo_full      = 1'b0;
    cfg_thres_load = 1'b0;
    cfg_thres      = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic settle(input string tag);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle_gnt"}, {28'h0, gnt}, 32'h0);
    exp_q.delete();
    #1;
  endtask

  initial begin
    req_data = '0;
    do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    check("rst_gnt", {28'h0, gnt}, 0);
    check("rst_we", {31'h0, fifo_write_enable}, 0);
    check("rst_data", {24'h0, fifo_data_in}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_thres", {26'h0, fifo_full_thres}, 32);
    do_reset();

    // single requester re-granted back to back
    req_data = 32'h0000_0078;
    push(4'b0001, 8'h78, 8);
    req = 4'b0001;
    @(negedge clock);
    check("t1_gnt_delay", {28'h0, gnt}, 0);
    repeat (9) @(posedge clock);
    #1 req = '0;
    settle("t1");

    // all four requesting: rotation with no bubble
    do_reset();
    req_data = 32'h1312_1110;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) push(4'(1 << i), 8'(8'h10 + i), 4);
    req = 4'b1111;
    repeat (33) @(posedge clock);
    #1 req = '0;
    settle("t2");

    // back-pressure mid-burst
    do_reset();
    req_data = 32'h3322_0000;
    push(4'b0100, 8'h22, 4);
    push(4'b1000, 8'h33, 4);
    req = 4'b1100;
    repeat (3) @(posedge clock);
    #1 fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t3_stall_we", {31'h0, fifo_write_enable}, 0);
      check("t3_stall_gnt", {28'h0, gnt}, 32'h4);
      check("t3_stall_data", {24'h0, fifo_data_in}, 0);
    end
    @(posedge clock);
    #1 fifo_full = 1'b0;
    repeat (6) @(posedge clock);
    #1 req = '0;
    settle("t3");

    // requester drops mid-burst, hand-over without bubble
    do_reset();
    req_data = 32'h8300_4100;
    push(4'b0010, 8'h41, 1);
    push(4'b1000, 8'h83, 4);
    req = 4'b1010;
    repeat (2) @(posedge clock);
    #1 req = 4'b1000;
    @(negedge clock);
    check("t4_hold_gnt", {28'h0, gnt}, 32'h2);
    check("t4_hold_we", {31'h0, fifo_write_enable}, 0);
    @(negedge clock);
    check("t4_switch_gnt", {28'h0, gnt}, 32'h8);
    repeat (4) @(posedge clock);
    #1 req = '0;
    settle("t4");

    // threshold load deferred until idle, immediate when idle
    do_reset();
    req_data = 32'h0000_0005;
    push(4'b0001, 8'h05, 2);
    req = 4'b0001;
    @(posedge clock);
    #1 begin cfg_thres = 6'd20; cfg_thres_load = 1'b1; end
    @(posedge clock);
    #1 cfg_thres_load = 1'b0;
    @(negedge clock);
    check("t5_thres_busy", {26'h0, fifo_full_thres}, 32);
    @(posedge clock);
    #1 req = '0;
    @(posedge clock);
    @(negedge clock);
    check("t5_first_idle_gnt", {28'h0, gnt}, 0);
    check("t5_first_idle_thres", {26'h0, fifo_full_thres}, 32);
    @(negedge clock);
    check("t5_applied_thres", {26'h0, fifo_full_thres}, 20);
    #1 begin cfg_thres = 6'd10; cfg_thres_load = 1'b1; end
    @(posedge clock);
    #1 cfg_thres_load = 1'b0;
    @(negedge clock);
    check("t5_idle_load", {26'h0, fifo_full_thres}, 10);
    settle("t5a");

    // reset mid-burst discards a pending (overwritten) load
    push(4'b0001, 8'h05, 3);
    req = 4'b0001;
    @(posedge clock);
    #1 begin cfg_thres = 6'd40; cfg_thres_load = 1'b1; end
    @(posedge clock);
    #1 cfg_thres = 6'd50;
    @(posedge clock);
    #1 begin cfg_thres_load = 1'b0; reset_n = 1'b0; end
    @(posedge clock);
    #1 begin reset_n = 1'b1; req = '0; end
    @(negedge clock);
    check("t5_rst_gnt", {28'h0, gnt}, 0);
    check("t5_rst_we", {31'h0, fifo_write_enable}, 0);
    repeat (3) @(negedge clock);
    check("t5_rst_thres", {26'h0, fifo_full_thres}, 32);
    settle("t5b");

    // late request from requester 0
    do_reset();
    req_data = 32'h1312_1110;
    push(4'b0010, 8'h11, 4);
`ifdef FIFO_ARB_PRIO0_EN
    push(4'b0001, 8'h10, 12);
`else
    push(4'b0100, 8'h12, 4);
    push(4'b1000, 8'h13, 4);
    push(4'b0001, 8'h10, 4);
`endif
    req = 4'b1110;
    @(posedge clock);
    #1 req = 4'b1111;
    repeat (16) @(posedge clock);
    #1 req = '0;
    settle("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
